// File: rtl/seg_memory_pkg.sv
// seg_memory_pkg: shared constants for the MEM stage
package seg_memory_pkg;
  localparam int MEMREAD  = 8;
  localparam int MEMWRITE = 7;
  localparam int BRANCH   = 6;
  localparam int BRANCHNE = 5;
  localparam int UNSIGNED = 4;
  localparam int SIZE_HI  = 3;
  localparam int SIZE_LO  = 2;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
endpackage

// File: rtl/seg_memory_align.sv
// seg_memory_align: byte-lane steering, alignment check and load extension
module seg_memory_align
  import seg_memory_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [1:0]     i_addr,
  input  logic [1:0]     i_size,
  input  logic           i_unsigned,
  input  logic [LEN-1:0] i_wdata,
  input  logic [LEN-1:0] i_rdata,
  output logic [3:0]     o_be,
  output logic [LEN-1:0] o_wdata,
  output logic [LEN-1:0] o_rdata,
  output logic           o_mis
);
  logic is_byte, is_half;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  // size 11 falls through to word handling everywhere
  always_comb begin
    is_byte = i_size == SZ_BYTE;
    is_half = i_size == SZ_HALF;
    lane_b = i_rdata[{i_addr, 3'b000} +: 8];
    lane_h = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_mis = is_half ? i_addr[0] : !is_byte & (i_addr != 2'b00);
    o_be = is_byte ? 4'b0001 << i_addr : is_half ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_wdata = is_byte ? {(LEN/8){i_wdata[7:0]}} : is_half ? {(LEN/16){i_wdata[15:0]}} : i_wdata;
    o_rdata = is_byte ? {{(LEN-8){!i_unsigned & lane_b[7]}}, lane_b} :
              is_half ? {{(LEN-16){!i_unsigned & lane_h[15]}}, lane_h} : i_rdata;
  end
endmodule

// File: rtl/seg_memory.sv
// seg_memory: MIPS MEM stage with req/ack data RAM access and MEM/WB register
module seg_memory
  import seg_memory_pkg::*;
#(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [LEN-1:0]        i_ALU_result,
  input  logic [LEN-1:0]        i_write_data,
  input  logic [NB_ADDR-1:0]    i_write_register,
  input  logic                  i_ALU_zero,
  input  logic [LEN-1:0]        i_PC_branch,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [LEN-1:0]        o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [LEN-1:0]        o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [LEN-1:0]        i_mem_rdata,
  output logic                  o_stall,
  output logic                  o_PCSrc,
  output logic [LEN-1:0]        o_PC_branch,
  output logic                  o_misaligned,
  output logic [LEN-1:0]        o_rd_mem_forwarding,
  output logic [LEN-1:0]        o_read_data,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus
);
  logic [0:0] state;
  logic idle, live, acc, mis, fault, unused_ok;
  logic [LEN-1:0] ext;

  seg_memory_align #(.LEN(LEN)) u_align (
    .i_addr     (i_ALU_result[1:0]),
    .i_size     (i_ctrl_mem_bus[SIZE_HI:SIZE_LO]),
    .i_unsigned (i_ctrl_mem_bus[UNSIGNED]),
    .i_wdata    (i_write_data),
    .i_rdata    (i_mem_rdata),
    .o_be       (o_mem_be),
    .o_wdata    (o_mem_wdata),
    .o_rdata    (ext),
    .o_mis      (mis)
  );

  assign unused_ok = ^i_ctrl_mem_bus[1:0];
  assign idle = state == ST_IDLE;
  assign live = i_valid & !i_flush;
  assign acc = live & (i_ctrl_mem_bus[MEMREAD] | i_ctrl_mem_bus[MEMWRITE]);
  assign fault = acc & mis;
  assign o_stall = idle ? acc & !mis : !i_mem_ack;
  assign o_mem_req = !idle & !i_rst;
  assign o_mem_we = o_mem_req & i_ctrl_mem_bus[MEMWRITE];
  assign o_mem_addr = {i_ALU_result[LEN-1:2], 2'b00};
  assign o_PCSrc = live & i_ctrl_mem_bus[BRANCH] & (i_ALU_zero ^ i_ctrl_mem_bus[BRANCHNE]);
  assign o_PC_branch = i_PC_branch;
  assign o_rd_mem_forwarding = i_ALU_result;

  // stalling means "an access is pending", so the stall itself steers the FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else state <= o_stall ? ST_ACCESS : ST_IDLE;
  end

  // MEM/WB register; a flush arriving mid-access must not kill the committing op
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_read_data      <= '0;
      o_ALU_result     <= '0;
      o_write_register <= '0;
      o_ctrl_wb_bus    <= '0;
    end else if (!o_stall) begin
      o_read_data      <= !idle & i_ctrl_mem_bus[MEMREAD] ? ext : '0;
      o_ALU_result     <= i_ALU_result;
      o_write_register <= i_write_register;
      o_ctrl_wb_bus    <= (idle & !live) | fault ? '0 : i_ctrl_wb_bus;
    end
  end

  // alignment fault is a one-cycle pulse alongside the bubble it creates
  always_ff @(posedge i_clk) begin
    if (i_rst) o_misaligned <= 1'b0;
    else o_misaligned <= fault;
  end
endmodule

// File: tb/tb_seg_memory.sv
// tb_seg_memory: randomized MEM-stage bench against a byte-level memory model
module tb_seg_memory;
  logic clk = 0, rst = 1;
  logic i_valid = 0, i_flush = 0, i_ALU_zero = 0, i_mem_ack = 0;
  logic [31:0] i_ALU_result = 0, i_write_data = 0, i_PC_branch = 0, i_mem_rdata = 0;
  logic [4:0] i_write_register = 0;
  logic [1:0] i_ctrl_wb_bus = 0;
  logic [8:0] i_ctrl_mem_bus = 0;
  logic o_mem_req, o_mem_we, o_stall, o_PCSrc, o_misaligned;
  logic [31:0] o_mem_addr, o_mem_wdata, o_PC_branch, o_rd_mem_forwarding, o_read_data, o_ALU_result;
  logic [3:0] o_mem_be;
  logic [4:0] o_write_register;
  logic [1:0] o_ctrl_wb_bus;

  int n_checks = 0, n_fail = 0;
  logic [31:0] ram [0:15];
  logic [7:0] mdl [0:63];
  int last_stalls;
  logic seen_req, seen_we;
  logic [3:0] seen_be;
  logic [31:0] seen_wd;

  seg_memory dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_ALU_result(i_ALU_result), .i_write_data(i_write_data),
    .i_write_register(i_write_register), .i_ALU_zero(i_ALU_zero),
    .i_PC_branch(i_PC_branch), .i_ctrl_wb_bus(i_ctrl_wb_bus),
    .i_ctrl_mem_bus(i_ctrl_mem_bus), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_stall(o_stall),
    .o_PCSrc(o_PCSrc), .o_PC_branch(o_PC_branch), .o_misaligned(o_misaligned),
    .o_rd_mem_forwarding(o_rd_mem_forwarding), .o_read_data(o_read_data),
    .o_ALU_result(o_ALU_result), .o_write_register(o_write_register),
    .o_ctrl_wb_bus(o_ctrl_wb_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    ram[w] = v;
    for (int k = 0; k < 4; k++) mdl[w*4+k] = v[8*k +: 8];
  endtask

  function automatic logic [8:0] mcb(input logic rd, input logic wr, input logic uns, input logic [1:0] sz);
    mcb = {rd, wr, 1'b0, 1'b0, uns, sz, 2'b00};
  endfunction

  // drives one instruction into MEM, answers the RAM handshake, then checks the commit
  task automatic run_op(input logic [8:0] cm, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] wb, input logic [4:0] rd, input int lat,
                        input logic fl, input logic late_fl, input logic zero);
    int n, r;
    logic done, ld, st, acc_e, mis_e, go;
    logic [1:0] sz;
    logic [31:0] exp_rd, pcb, mask, lanes;
    logic [3:0] exp_be;
    sz = cm[3:2];
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    ld = cm[8];
    st = cm[7];
    acc_e = !fl & (ld | st);
    mis_e = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    go = acc_e & !mis_e;
    exp_rd = 0;
    exp_be = 0;
    mask = 0;
    lanes = 0;
    if (!mis_e) begin
      for (int k = 0; k < n; k++) begin
        exp_rd = exp_rd | (32'(mdl[int'(a[5:0]) + k]) << (8*k));
        exp_be[int'(a[1:0]) + k] = 1'b1;
        mask[8*(int'(a[1:0]) + k) +: 8] = 8'hFF;
        lanes[8*(int'(a[1:0]) + k) +: 8] = wd[8*k +: 8];
      end
      if (n < 4 && !cm[4] && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFFFFFF << (8*n));
    end
    pcb = $urandom;
    @(posedge clk) #1;
    i_valid = 1; i_flush = fl; i_ALU_result = a; i_write_data = wd; i_write_register = rd;
    i_ctrl_wb_bus = wb; i_ctrl_mem_bus = cm; i_ALU_zero = zero; i_PC_branch = pcb;
    last_stalls = 0; r = 0; done = 0; seen_req = 0; seen_we = 0; seen_be = 0; seen_wd = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("pcsrc", 32'(o_PCSrc), 32'(!fl & cm[6] & (zero ^ cm[5])));
        chk("pc_branch", o_PC_branch, pcb);
        chk("forward", o_rd_mem_forwarding, a);
      end
      if (o_mem_req) begin
        if (!seen_req) begin
          seen_req = 1; seen_be = o_mem_be; seen_wd = o_mem_wdata; seen_we = o_mem_we;
          chk("mem_addr", o_mem_addr, {a[31:2], 2'b00});
          if (late_fl) i_flush = 1;
        end
        if (r == lat) begin
          i_mem_ack = 1;
          i_mem_rdata = ram[o_mem_addr[5:2]];
          if (o_mem_we)
            for (int l = 0; l < 4; l++)
              if (o_mem_be[l]) ram[o_mem_addr[5:2]][8*l +: 8] = o_mem_wdata[8*l +: 8];
        end
        r++;
      end
      #1;
      if (o_stall) last_stalls++;
      else done = 1;
    end
    chk("completes", 32'(done), 32'd1);
    @(posedge clk) #1;
    i_mem_ack = 0; i_valid = 0; i_flush = 0;
    @(negedge clk);
    chk("stalls", 32'(last_stalls), go ? 32'(lat + 1) : 32'd0);
    chk("req_issued", 32'(seen_req), 32'(go));
    if (go) begin
      chk("we", 32'(seen_we), 32'(st));
      chk("be", 32'(seen_be), 32'(exp_be));
      if (st) chk("wdata_lanes", seen_wd & mask, lanes);
      if (ld) chk("read_data", o_read_data, exp_rd);
      if (st) for (int k = 0; k < n; k++) mdl[int'(a[5:0]) + k] = wd[8*k +: 8];
    end
    if (!ld) chk("read_data_nonload", o_read_data, 32'd0);
    chk("ctrl_wb", 32'(o_ctrl_wb_bus), (fl || (acc_e && mis_e)) ? 32'd0 : 32'(wb));
    chk("alu_result", o_ALU_result, a);
    chk("wr_reg", 32'(o_write_register), 32'(rd));
    chk("misaligned", 32'(o_misaligned), 32'(acc_e & mis_e));
  endtask

  initial begin
    logic [8:0] cm;
    logic [31:0] a;
    int t, n;
    for (int w = 0; w < 16; w++) poke(w, $urandom);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", 32'(o_mem_req), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_read_data", o_read_data, 0);
    chk("rst_alu", o_ALU_result, 0);
    chk("rst_wr_reg", 32'(o_write_register), 0);
    chk("rst_ctrl_wb", 32'(o_ctrl_wb_bus), 0);
    chk("rst_mis", 32'(o_misaligned), 0);

    run_op(mcb(0, 1, 0, 2'b10), 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, 2, 0, 0, 0);
    chk("sw_stalls", 32'(last_stalls), 3);
    chk("sw_be", 32'(seen_be), 32'hF);
    run_op(mcb(1, 0, 0, 2'b10), 32'h10, 32'h0, 2'b11, 5'd5, 2, 0, 0, 0);
    chk("lw_stalls", 32'(last_stalls), 3);
    chk("lw_data", o_read_data, 32'hDEADBEEF);
    chk("lw_ctrl", 32'(o_ctrl_wb_bus), 32'h3);
    poke(4, 32'h80FFFFFF);
    run_op(mcb(1, 0, 0, 2'b00), 32'h13, 32'h0, 2'b11, 5'd6, 1, 0, 0, 0);
    chk("lb_be", 32'(seen_be), 32'h8);
    chk("lb_data", o_read_data, 32'hFFFFFF80);
    run_op(mcb(1, 0, 1, 2'b00), 32'h13, 32'h0, 2'b11, 5'd6, 0, 0, 0, 0);
    chk("lbu_data", o_read_data, 32'h00000080);
    run_op(mcb(0, 1, 0, 2'b01), 32'h22, 32'h0000ABCD, 2'b00, 5'd0, 0, 0, 0, 0);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wd, 32'hABCDABCD);
    chk("sh_we", 32'(seen_we), 1);
    run_op(mcb(1, 0, 0, 2'b10), 32'h05, 32'h0, 2'b11, 5'd7, 0, 0, 0, 0);
    chk("mis_req", 32'(seen_req), 0);
    chk("mis_pulse", 32'(o_misaligned), 1);
    chk("mis_ctrl", 32'(o_ctrl_wb_bus), 0);
    @(negedge clk);
    chk("mis_one_cycle", 32'(o_misaligned), 0);
    run_op(9'b001000000, 32'h0, 32'h0, 2'b10, 5'd1, 0, 0, 0, 1);
    run_op(9'b001100000, 32'h0, 32'h0, 2'b10, 5'd1, 0, 0, 0, 1);
    run_op(9'b001000000, 32'h0, 32'h0, 2'b10, 5'd1, 0, 1, 0, 1);
    run_op(mcb(1, 0, 0, 2'b10), 32'h10, 32'h0, 2'b11, 5'd9, 2, 0, 1, 0);
    chk("flush_access_ctrl", 32'(o_ctrl_wb_bus), 32'h3);

    @(posedge clk) #1;
    i_valid = 1; i_ALU_result = 32'h10; i_ctrl_mem_bus = mcb(1, 0, 0, 2'b10);
    i_ctrl_wb_bus = 2'b11; i_write_register = 5'd3;
    @(negedge clk);
    chk("rstmid_enter", 32'(o_stall), 1);
    @(posedge clk) #1;
    @(negedge clk);
    chk("rstmid_req", 32'(o_mem_req), 1);
    @(posedge clk) #1 rst = 1;
    @(posedge clk) #1;
    rst = 0; i_valid = 0; i_mem_ack = 1; i_mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rstmid_req0", 32'(o_mem_req), 0);
    chk("rstmid_stall0", 32'(o_stall), 0);
    chk("rstmid_rd", o_read_data, 0);
    chk("rstmid_alu", o_ALU_result, 0);
    chk("rstmid_wr", 32'(o_write_register), 0);
    chk("rstmid_ctrl", 32'(o_ctrl_wb_bus), 0);
    @(posedge clk) #1 i_mem_ack = 0;
    @(negedge clk);
    chk("late_ack_req", 32'(o_mem_req), 0);
    chk("late_ack_stall", 32'(o_stall), 0);
    chk("late_ack_rd", o_read_data, 0);
    chk("late_ack_ctrl", 32'(o_ctrl_wb_bus), 0);

    for (int i = 0; i < 200; i++) begin
      t = $urandom_range(0, 3);
      cm = 0;
      cm[1:0] = 2'($urandom);
      if (t < 2) begin
        cm[8 - t] = 1'b1;
        cm[3:2] = 2'($urandom_range(0, 3));
        cm[4] = 1'($urandom);
      end else if (t == 2) begin
        cm[6] = 1'b1;
        cm[5] = 1'($urandom);
      end
      n = cm[3:2] == 2'd0 ? 1 : cm[3:2] == 2'd1 ? 2 : 4;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~32'(n - 1);
      run_op(cm, a, $urandom, 2'($urandom), 5'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
